// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen
//   Raster timing generator with a built-in 30-bit RGB test pattern. It feeds
//   the line buffer controller, so the downstream block sees a frame stream
//   with known, repeatable content.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            asynchronous, active-high reset
//   i_en           run request (level); dropping it lets the current frame finish
//   i_pat_sel      pattern select: 0=index, 1=checker, 2=white, 3=black
//   o_busy         high while the generator is running or draining
//   o_frame_start  one-cycle pulse on the output cycle of (h=0, v=0)
//   o_vsync        active-high vertical sync
//   o_hsync        active-high horizontal sync
//   o_de           active-high data enable
//   o_r_data       red   (10 bits)
//   o_g_data       green (10 bits)
//   o_b_data       blue  (10 bits)
module video_timing_pattern_gen #(
  parameter int HSW      = 2,
  parameter int HBP      = 2,
  parameter int HACT     = 10,
  parameter int HFP      = 1,
  parameter int VSW      = 1,
  parameter int VBP      = 1,
  parameter int VACT     = 4,
  parameter int VFP      = 1,
  parameter int CHK_LOG2 = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_pat_sel,
  output logic       o_busy,
  output logic       o_frame_start,
  output logic       o_vsync,
  output logic       o_hsync,
  output logic       o_de,
  output logic [9:0] o_r_data,
  output logic [9:0] o_g_data,
  output logic [9:0] o_b_data
);

  localparam int HTOT = HSW + HBP + HACT + HFP;
  localparam int VTOT = VSW + VBP + VACT + VFP;
  localparam int HW   = (HTOT > 1) ? $clog2(HTOT) : 1;
  localparam int VW   = (VTOT > 1) ? $clog2(VTOT) : 1;

  localparam logic [HW-1:0] H_LAST      = HW'(HTOT - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(VTOT - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(HSW);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(VSW);
  localparam logic [HW-1:0] H_ACT_START = HW'(HSW + HBP);
  localparam logic [HW-1:0] H_ACT_END   = HW'(HSW + HBP + HACT);
  localparam logic [VW-1:0] V_ACT_START = VW'(VSW + VBP);
  localparam logic [VW-1:0] V_ACT_END   = VW'(VSW + VBP + VACT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [9:0]    frame_cnt;
  logic [1:0]    pat_reg;

  logic          at_origin, at_end;
  logic          active_p0, frame_start_p0;
  logic          hsync_p0, vsync_p0, de_p0;
  logic [HW-1:0] x_p0;
  logic [VW-1:0] y_p0;
  logic [29:0]   pix_p0;

  // RGB for one active pixel; blanking is applied by the caller.
  function automatic logic [29:0] pattern_pixel(input logic [1:0]    pat,
                                                input logic [HW-1:0] x,
                                                input logic [VW-1:0] y,
                                                input logic [9:0]    fc);
    logic [29:0] px;
    case (pat)
      2'd0:    px = {10'(x), 10'(y), fc};
      2'd1:    px = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? {30{1'b1}} : 30'd0;
      2'd2:    px = {30{1'b1}};
      default: px = 30'd0;
    endcase
    return px;
  endfunction

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign at_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // active_p0: the current (h,v) is emitted this cycle and the counters advance.
  // Dropping i_en exactly on the last pixel of a frame still emits that pixel
  // but stops at the boundary instead of entering DRAIN for a whole new frame.
  always_comb begin
    state_nxt = state;
    active_p0 = 1'b0;
    case (state)
      IDLE: begin
        if (i_en) state_nxt = RUN;
      end
      RUN: begin
        if (i_en) begin
          active_p0 = 1'b1;
        end else if (at_origin) begin
          state_nxt = IDLE;
        end else begin
          active_p0 = 1'b1;
          state_nxt = at_end ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        active_p0 = 1'b1;
        if (at_end) state_nxt = i_en ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (active_p0) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 10'd1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // Stage p0: timing decode and pattern from the live counters.
  assign frame_start_p0 = active_p0 && at_origin;
  assign hsync_p0       = h_cnt < H_SYNC_END;
  assign vsync_p0       = v_cnt < V_SYNC_END;
  assign de_p0          = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END) &&
                          (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
  assign x_p0           = h_cnt - H_ACT_START;
  assign y_p0           = v_cnt - V_ACT_START;
  assign pix_p0         = pattern_pixel(pat_reg, x_p0, y_p0, frame_cnt);

  // The origin pixel is always blanking, so loading pat_reg on that same
  // cycle lets the whole visible frame use the newly captured pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pat_reg <= 2'd0;
    else if (frame_start_p0) pat_reg <= i_pat_sel;
  end

  // Stage p1: registered outputs, all aligned one clock after the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_busy        <= 1'b0;
      o_frame_start <= 1'b0;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_de          <= 1'b0;
      o_r_data      <= '0;
      o_g_data      <= '0;
      o_b_data      <= '0;
    end else begin
      o_busy        <= (state != IDLE);
      o_frame_start <= frame_start_p0;
      o_hsync       <= active_p0 && hsync_p0;
      o_vsync       <= active_p0 && vsync_p0;
      o_de          <= active_p0 && de_p0;
      if (active_p0 && de_p0) begin
        {o_r_data, o_g_data, o_b_data} <= pix_p0;
      end else begin
        o_r_data <= '0;
        o_g_data <= '0;
        o_b_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
module tb_video_timing_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_en;
  logic [1:0] i_pat_sel;
  logic       o_busy, o_frame_start, o_vsync, o_hsync, o_de;
  logic [9:0] o_r_data, o_g_data, o_b_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_timing_pattern_gen dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_pat_sel     (i_pat_sel),
    .o_busy        (o_busy),
    .o_frame_start (o_frame_start),
    .o_vsync       (o_vsync),
    .o_hsync       (o_hsync),
    .o_de          (o_de),
    .o_r_data      (o_r_data),
    .o_g_data      (o_g_data),
    .o_b_data      (o_b_data)
  );

  // {busy, frame_start, vsync, hsync, de, r, g, b}
  function automatic logic [34:0] act_vec();
    return {o_busy, o_frame_start, o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data};
  endfunction

  // Expected outputs for frame offset n (HTOT=15, VTOT=7, active h 4..13, v 2..5).
  function automatic logic [34:0] exp_vec(int n, int pat, int fc);
    int h, v, x, y;
    logic de;
    logic [9:0] r, g, b;
    h  = n % 15;
    v  = (n / 15) % 7;
    x  = h - 4;
    y  = v - 2;
    de = (h >= 4) && (h < 14) && (v >= 2) && (v < 6);
    r = 10'd0; g = 10'd0; b = 10'd0;
    if (de) begin
      case (pat)
        0: begin r = 10'(x); g = 10'(y); b = 10'(fc % 1024); end
        1: begin
          r = ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 10'h3FF : 10'h000;
          g = r; b = r;
        end
        2: begin r = 10'h3FF; g = 10'h3FF; b = 10'h3FF; end
        default: ;
      endcase
    end
    return {1'b1, (h == 0 && v == 0), (v < 1), (h < 2), de, r, g, b};
  endfunction

  task automatic wait_fs(output bit ok);
    int cnt;
    ok  = 1'b0;
    cnt = 0;
    while (!ok && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (o_frame_start) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [34:0] a;
    rst = 1'b1; i_en = 1'b0; i_pat_sel = 2'd0;
    repeat (3) @(negedge clk);
    a = act_vec();
    checks++;
    if (a !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", a, 35'd0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    a = act_vec();
    checks++;
    if (a !== 35'd0) begin
      errors++;
      $display("FAIL idle_outputs got=%h exp=%h", a, 35'd0);
    end
  endtask

  task automatic test_index();
    bit ok;
    logic [34:0] a, e;
    i_en = 1'b1; i_pat_sel = 2'd0;
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL index_fs_timeout seen=%0d exp=1", ok);
    end
    for (int n = 0; n < 210; n++) begin
      if (n > 0) @(negedge clk);
      a = act_vec();
      e = exp_vec(n, 0, n / 105);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL index n=%0d got=%h exp=%h", n, a, e);
      end
    end
    // first active pixel (h=4,v=2) and last active pixel (h=13,v=5) of frame 0
    e = exp_vec(34, 0, 0);
    checks++;
    if (e[29:0] !== 30'd0) begin
      errors++;
      $display("FAIL index_first_px got=%h exp=%h", e[29:0], 30'd0);
    end
    e = exp_vec(88, 0, 0);
    checks++;
    if (e[29:10] !== {10'd9, 10'd3}) begin
      errors++;
      $display("FAIL index_last_px got=%h exp=%h", e[29:10], {10'd9, 10'd3});
    end
  endtask

  task automatic test_checker();
    bit ok;
    logic [34:0] a, e;
    bit row0 [10];
    int h, v;
    logic [9:0] want;
    row0 = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    i_pat_sel = 2'd1;
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL checker_fs_timeout seen=%0d exp=1", ok);
    end
    for (int n = 0; n < 105; n++) begin
      if (n > 0) @(negedge clk);
      a = act_vec();
      e = exp_vec(n, 1, 0);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL checker n=%0d got=%h exp=%h", n, a, e);
      end
      h = n % 15;
      v = n / 15;
      if ((v == 2 || v == 4) && h >= 4 && h < 14) begin
        want = ((row0[h - 4] == 1'b1) ^ (v == 4)) ? 10'h3FF : 10'h000;
        checks++;
        if (o_g_data !== want) begin
          errors++;
          $display("FAIL checker_row v=%0d h=%0d got=%h exp=%h", v, h, o_g_data, want);
        end
      end
    end
  endtask

  task automatic test_pat_switch();
    bit ok;
    logic [34:0] a, e;
    i_pat_sel = 2'd2;
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL switch_fs_timeout seen=%0d exp=1", ok);
    end
    for (int n = 0; n < 210; n++) begin
      if (n > 0) @(negedge clk);
      a = act_vec();
      e = exp_vec(n, (n < 105) ? 2 : 3, 0);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pat_switch n=%0d got=%h exp=%h", n, a, e);
      end
      if (n == 50) i_pat_sel = 2'd3;
    end
  endtask

  task automatic test_drain();
    bit ok;
    logic [34:0] a, e;
    i_pat_sel = 2'd2;
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_fs_timeout seen=%0d exp=1", ok);
    end
    for (int n = 0; n < 168; n++) begin
      if (n > 0) @(negedge clk);
      a = act_vec();
      if (n < 105)      e = exp_vec(n, 2, 0);
      else if (n < 116) e = 35'd0;
      else              e = exp_vec(n - 116, 2, 0);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL drain n=%0d got=%h exp=%h", n, a, e);
      end
      // i_en low while the counters hold (7,3); re-raised after the idle gap
      if (n == 51)  i_en = 1'b0;
      if (n == 114) i_en = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    logic [34:0] a, e;
    checks++;
    if (o_de !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_de got=%b exp=1", o_de);
    end
    #2 rst = 1'b1;
    #1 a = act_vec();
    checks++;
    if (a !== 35'd0) begin
      errors++;
      $display("FAIL areset_immediate got=%h exp=%h", a, 35'd0);
    end
    i_pat_sel = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n < 107; n++) begin
      @(negedge clk);
      a = act_vec();
      e = (n < 2) ? 35'd0 : exp_vec(n - 2, 0, 0);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL areset_restart n=%0d got=%h exp=%h", n, a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_index();
    test_checker();
    test_pat_switch();
    test_drain();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
